// File: rtl/cmd_pkg.sv
// Shared types and default response bytes for the command executor.
//   cmd_type_e   : command opcode carried in every packet
//   cmd_packet_t : 18-bit packet popped from the command FIFO
//   *_DEF        : default response byte values
package cmd_pkg;

  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_WR   = 2'd1,
    CMD_RD   = 2'd2,
    CMD_RSVD = 2'd3
  } cmd_type_e;

  typedef struct packed {
    cmd_type_e   cmd_type;
    logic [7:0]  addr;
    logic [7:0]  data;
  } cmd_packet_t;

  localparam logic [7:0] ACK_WR_DEF  = 8'hA5;
  localparam logic [7:0] ACK_RD_DEF  = 8'hAD;
  localparam logic [7:0] ERR_CMD_DEF = 8'hEE;
  localparam logic [7:0] ERR_TMO_DEF = 8'hEF;

endpackage

// File: rtl/cmd_executor.sv
// Command executor: pops command packets from a FWFT FIFO, performs one
// register-bus access per command (write, read or NOP) and pushes the
// response bytes into the TX byte FIFO. Sole master of the register bus.
//
// Ports
//   clk, rst                      clock, async active-high reset
//   cmd_fifo_empty/rd_data/rd_en  command FIFO (FWFT) pop interface
//   reg_addr/wr_data/wr_en/rd_en  register bus request side
//   reg_rd_data/reg_rd_valid      register bus read return
//   tx_full/tx_wr_en/tx_wr_data   TX byte FIFO push interface
//   busy                          high whenever a command is in flight
//   err_count                     saturating count of error responses
//
// state     | meaning
// S_IDLE    | waiting for a command in the FIFO
// S_EXEC    | decode cmd_q and issue the bus strobe
// S_WAIT_RD | waiting for reg_rd_valid or the read timeout
// S_RESP    | pushing the response/header byte
// S_RESP_D  | pushing the read data byte
module cmd_executor
  import cmd_pkg::*;
#(
  parameter int         RD_TIMEOUT = 64,
  parameter logic [7:0] ACK_WR     = ACK_WR_DEF,
  parameter logic [7:0] ACK_RD     = ACK_RD_DEF,
  parameter logic [7:0] ERR_CMD    = ERR_CMD_DEF,
  parameter logic [7:0] ERR_TMO    = ERR_TMO_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_fifo_empty,
  input  cmd_packet_t cmd_fifo_rd_data,
  output logic        cmd_fifo_rd_en,
  output logic [7:0]  reg_addr,
  output logic [7:0]  reg_wr_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  input  logic [7:0]  reg_rd_data,
  input  logic        reg_rd_valid,
  input  logic        tx_full,
  output logic        tx_wr_en,
  output logic [7:0]  tx_wr_data,
  output logic        busy,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_EXEC    = 3'd1,
    S_WAIT_RD = 3'd2,
    S_RESP    = 3'd3,
    S_RESP_D  = 3'd4
  } state_e;

  localparam int TMO_W = $clog2(RD_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

  state_e           state_q;
  cmd_packet_t      cmd_q;
  logic [7:0]       rd_q;
  logic [7:0]       resp_q;
  logic             send_data_q;
  logic [TMO_W-1:0] tmo_cnt_q;
  logic [7:0]       err_cnt_q;
  logic             cmd_rd_en_q;
  logic [7:0]       reg_addr_q;
  logic [7:0]       reg_wr_data_q;
  logic             reg_wr_en_q;
  logic             reg_rd_en_q;
  logic             tx_wr_en_q;
  logic [7:0]       tx_wr_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cmd_q         <= '0;
      rd_q          <= '0;
      resp_q        <= '0;
      send_data_q   <= 1'b0;
      tmo_cnt_q     <= '0;
      err_cnt_q     <= '0;
      cmd_rd_en_q   <= 1'b0;
      reg_addr_q    <= '0;
      reg_wr_data_q <= '0;
      reg_wr_en_q   <= 1'b0;
      reg_rd_en_q   <= 1'b0;
      tx_wr_en_q    <= 1'b0;
      tx_wr_data_q  <= '0;
    end else begin
      // strobes are single-cycle unless re-asserted below
      cmd_rd_en_q <= 1'b0;
      reg_wr_en_q <= 1'b0;
      reg_rd_en_q <= 1'b0;
      tx_wr_en_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (!cmd_fifo_empty) begin
            cmd_q       <= cmd_fifo_rd_data;
            cmd_rd_en_q <= 1'b1;
            state_q     <= S_EXEC;
          end
        end
        S_EXEC: begin
          reg_addr_q    <= cmd_q.addr;
          reg_wr_data_q <= cmd_q.data;
          case (cmd_q.cmd_type)
            CMD_NOP: state_q <= S_IDLE;
            CMD_WR: begin
              reg_wr_en_q <= 1'b1;
              resp_q      <= ACK_WR;
              state_q     <= S_RESP;
            end
            CMD_RD: begin
              reg_rd_en_q <= 1'b1;
              tmo_cnt_q   <= '0;
              state_q     <= S_WAIT_RD;
            end
            default: begin
              resp_q  <= ERR_CMD;
              if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
              state_q <= S_RESP;
            end
          endcase
        end
        S_WAIT_RD: begin
          // valid has priority over a timeout expiring in the same cycle
          if (reg_rd_valid) begin
            rd_q        <= reg_rd_data;
            resp_q      <= ACK_RD;
            send_data_q <= 1'b1;
            state_q     <= S_RESP;
          end else if (tmo_cnt_q == TMO_LAST) begin
            resp_q  <= ERR_TMO;
            if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
            state_q <= S_RESP;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
          end
        end
        S_RESP: begin
          if (!tx_full) begin
            tx_wr_en_q   <= 1'b1;
            tx_wr_data_q <= resp_q;
            state_q      <= send_data_q ? S_RESP_D : S_IDLE;
          end
        end
        S_RESP_D: begin
          if (!tx_full) begin
            tx_wr_en_q   <= 1'b1;
            tx_wr_data_q <= rd_q;
            send_data_q  <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_fifo_rd_en = cmd_rd_en_q;
  assign reg_addr       = reg_addr_q;
  assign reg_wr_data    = reg_wr_data_q;
  assign reg_wr_en      = reg_wr_en_q;
  assign reg_rd_en      = reg_rd_en_q;
  assign tx_wr_en       = tx_wr_en_q;
  assign tx_wr_data     = tx_wr_data_q;
  assign busy           = (state_q != S_IDLE);
  assign err_count      = err_cnt_q;

endmodule

// File: tb/tb_cmd_executor.sv
`timescale 1ns/1ps
module tb_cmd_executor;
  import cmd_pkg::*;

  localparam int RD_TIMEOUT = 64;
  localparam int TX_DEPTH   = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_fifo_empty;
  cmd_packet_t cmd_fifo_rd_data;
  logic        cmd_fifo_rd_en;
  logic [7:0]  reg_addr, reg_wr_data, reg_rd_data;
  logic        reg_wr_en, reg_rd_en, reg_rd_valid;
  logic        tx_full, tx_wr_en, busy;
  logic [7:0]  tx_wr_data, err_count;

  cmd_executor #(.RD_TIMEOUT(RD_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_fifo_empty(cmd_fifo_empty), .cmd_fifo_rd_data(cmd_fifo_rd_data),
    .cmd_fifo_rd_en(cmd_fifo_rd_en),
    .reg_addr(reg_addr), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
    .reg_rd_en(reg_rd_en), .reg_rd_data(reg_rd_data), .reg_rd_valid(reg_rd_valid),
    .tx_full(tx_full), .tx_wr_en(tx_wr_en), .tx_wr_data(tx_wr_data),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n  = 0;
  int err_exp = 0;

  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  // ---------------- observed events ----------------
  typedef struct { logic [7:0] a; logic [7:0] d; int cyc; } ev_t;
  ev_t wr_ev[$];
  ev_t rd_ev[$];
  ev_t tx_ev[$];
  int  pop_ev[$];

  task automatic clear_ev();
    wr_ev.delete(); rd_ev.delete(); tx_ev.delete(); pop_ev.delete();
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (cmd_fifo_rd_en) pop_ev.push_back(cyc_n);
      if (reg_wr_en) wr_ev.push_back('{reg_addr, reg_wr_data, cyc_n});
      if (reg_rd_en) rd_ev.push_back('{reg_addr, 8'h00, cyc_n});
      if (tx_wr_en) begin
        tx_ev.push_back('{8'h00, tx_wr_data, cyc_n});
        check("tx_push_while_full", tx_full, 0);
      end
    end
  end

  // ---------------- command FIFO model (FWFT) ----------------
  cmd_packet_t cq[$];
  logic pop_pend;

  function automatic void fifo_refresh();
    cmd_fifo_empty   = (cq.size() == 0);
    cmd_fifo_rd_data = (cq.size() != 0) ? cq[0] : '0;
  endfunction

  task automatic push_cmd(input logic [1:0] typ, input logic [7:0] a, input logic [7:0] d);
    cmd_packet_t p;
    p.cmd_type = cmd_type_e'(typ);
    p.addr     = a;
    p.data     = d;
    cq.push_back(p);
    fifo_refresh();
  endtask

  initial forever begin
    @(negedge clk);
    pop_pend = cmd_fifo_rd_en;
    @(posedge clk); #1;
    if (pop_pend && cq.size() != 0) void'(cq.pop_front());
    fifo_refresh();
  end

  // ---------------- register read responder ----------------
  int         lat_q[$];
  logic [7:0] rdd_q[$];

  initial begin
    reg_rd_valid = 1'b0;
    reg_rd_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (reg_rd_en && !rst) begin
        int l;
        logic [7:0] d;
        l = (lat_q.size() != 0) ? lat_q.pop_front() : -1;
        d = (rdd_q.size() != 0) ? rdd_q.pop_front() : 8'h00;
        if (l > 0) begin
          repeat (l) @(posedge clk);
          #1 reg_rd_valid = 1'b1; reg_rd_data = d;
          @(posedge clk);
          #1 reg_rd_valid = 1'b0; reg_rd_data = 8'($urandom);
        end
      end
    end
  end

  // ---------------- TX FIFO model ----------------
  int   tx_cnt = 0;
  int   drain_pct = 100;
  logic force_full = 1'b0;
  logic tx_push;

  initial begin
    tx_full = 1'b0;
    forever begin
      @(negedge clk);
      tx_push = tx_wr_en;
      @(posedge clk); #1;
      if (tx_push) tx_cnt++;
      if (tx_cnt > 0 && int'($urandom_range(99)) < drain_pct) tx_cnt--;
      tx_full = force_full || (tx_cnt >= TX_DEPTH);
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int quiet;
    quiet = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cq.size() == 0 && !busy && !cmd_fifo_rd_en) quiet++;
      else quiet = 0;
      if (quiet >= 3) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: still busy after %0d cycles, required idle", tag, budget);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_strobes"}, {cmd_fifo_rd_en, reg_wr_en, reg_rd_en, tx_wr_en, busy}, 0);
    check({tag, "_buses"}, {reg_addr, reg_wr_data, tx_wr_data, err_count}, 0);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [1:0] typ;
    logic [7:0] addr;
    logic [7:0] data;
    int         lat;
    logic [7:0] rdata;
    int         n_tx;
    logic [7:0] b0;
    logic [7:0] b1;
    int         n_wr;
    int         n_rd;
    int         err_inc;
  } vec_t;

  vec_t vt[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_tx[$];
    logic [15:0] exp_wr[$];
    logic [7:0] exp_rd[$];
    int n;

    vt[0] = '{2'd1, 8'h10, 8'h3C, 0,  8'h00, 1, 8'hA5, 8'h00, 1, 0, 0};
    vt[1] = '{2'd2, 8'h22, 8'h00, 3,  8'h5A, 2, 8'hAD, 8'h5A, 0, 1, 0};
    vt[2] = '{2'd3, 8'h33, 8'h11, 0,  8'h00, 1, 8'hEE, 8'h00, 0, 0, 1};
    vt[3] = '{2'd0, 8'h34, 8'h12, 0,  8'h00, 0, 8'h00, 8'h00, 0, 0, 0};
    vt[4] = '{2'd2, 8'h44, 8'h00, 1,  8'hC3, 2, 8'hAD, 8'hC3, 0, 1, 0};
    vt[5] = '{2'd2, 8'h45, 8'h00, 63, 8'h99, 2, 8'hAD, 8'h99, 0, 1, 0};
    vt[6] = '{2'd2, 8'h46, 8'h00, 64, 8'h77, 1, 8'hEF, 8'h00, 0, 1, 1};
    vt[7] = '{2'd1, 8'hFF, 8'h00, 0,  8'h00, 1, 8'hA5, 8'h00, 1, 0, 0};

    rst = 1'b1;
    fifo_refresh();
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // -------- table: single commands with TX always empty --------
    for (int i = 0; i < 8; i++) begin
      int exp_cyc;
      clear_ev();
      if (vt[i].typ == 2'd2) begin
        lat_q.push_back(vt[i].lat);
        rdd_q.push_back(vt[i].rdata);
      end
      push_cmd(vt[i].typ, vt[i].addr, vt[i].data);
      wait_idle(200, $sformatf("v%0d_idle", i));
      err_exp = sat(err_exp + vt[i].err_inc);
      check($sformatf("v%0d_ntx", i), tx_ev.size(), vt[i].n_tx);
      if (tx_ev.size() > 0) check($sformatf("v%0d_b0", i), tx_ev[0].d, vt[i].b0);
      if (vt[i].n_tx > 1 && tx_ev.size() > 1) begin
        check($sformatf("v%0d_b1", i), tx_ev[1].d, vt[i].b1);
        check($sformatf("v%0d_b1_gap", i), tx_ev[1].cyc - tx_ev[0].cyc, 1);
      end
      check($sformatf("v%0d_nwr", i), wr_ev.size(), vt[i].n_wr);
      if (wr_ev.size() > 0) begin
        check($sformatf("v%0d_wr", i), {wr_ev[0].a, wr_ev[0].d}, {vt[i].addr, vt[i].data});
        if (pop_ev.size() > 0) check($sformatf("v%0d_wr_lat", i), wr_ev[0].cyc - pop_ev[0], 1);
      end
      check($sformatf("v%0d_nrd", i), rd_ev.size(), vt[i].n_rd);
      if (rd_ev.size() > 0) begin
        check($sformatf("v%0d_rd_addr", i), rd_ev[0].a, vt[i].addr);
        if (pop_ev.size() > 0) check($sformatf("v%0d_rd_lat", i), rd_ev[0].cyc - pop_ev[0], 1);
      end
      if (tx_ev.size() > 0 && pop_ev.size() > 0) begin
        if (vt[i].typ != 2'd2) exp_cyc = 2;
        else if (vt[i].lat < RD_TIMEOUT) exp_cyc = vt[i].lat + 3;
        else exp_cyc = RD_TIMEOUT + 2;
        check($sformatf("v%0d_tx_lat", i), tx_ev[0].cyc - pop_ev[0], exp_cyc);
      end
      check($sformatf("v%0d_err", i), err_count, err_exp);
      check($sformatf("v%0d_busy", i), busy, 0);
    end

    // -------- read timeout, valid arriving afterwards is ignored --------
    clear_ev();
    lat_q.push_back(70);
    rdd_q.push_back(8'h5A);
    push_cmd(2'd2, 8'h30, 8'h00);
    wait_idle(200, "tmo_idle");
    repeat (12) @(negedge clk);
    err_exp = sat(err_exp + 1);
    check("tmo_ntx", tx_ev.size(), 1);
    if (tx_ev.size() > 0) check("tmo_byte", tx_ev[0].d, 8'hEF);
    if (tx_ev.size() > 0 && rd_ev.size() > 0)
      check("tmo_cycles", tx_ev[0].cyc - rd_ev[0].cyc, RD_TIMEOUT + 1);
    check("tmo_err", err_count, err_exp);
    check("tmo_busy", busy, 0);

    // -------- TX full held across a read response --------
    clear_ev();
    force_full = 1'b1;
    repeat (2) @(negedge clk);
    lat_q.push_back(3);
    rdd_q.push_back(8'h5A);
    push_cmd(2'd2, 8'h22, 8'h00);
    repeat (8) @(negedge clk);
    repeat (10) @(negedge clk);
    check("full_no_push", tx_ev.size(), 0);
    check("full_busy", busy, 1);
    force_full = 1'b0;
    wait_idle(100, "full_idle");
    check("full_ntx", tx_ev.size(), 2);
    if (tx_ev.size() > 1) begin
      check("full_bytes", {tx_ev[0].d, tx_ev[1].d}, 16'hAD5A);
      check("full_gap", tx_ev[1].cyc - tx_ev[0].cyc, 1);
    end

    // -------- reset in the middle of the 2nd of four writes --------
    clear_ev();
    push_cmd(2'd1, 8'h51, 8'hA1);
    push_cmd(2'd1, 8'h52, 8'hA2);
    push_cmd(2'd1, 8'h53, 8'hA3);
    push_cmd(2'd1, 8'h54, 8'hA4);
    n = 0;
    for (int i = 0; i < 50 && n < 2; i++) begin
      @(negedge clk);
      if (cmd_fifo_rd_en) n++;
    end
    check("rst_saw_pop2", n, 2);
    #1 rst = 1'b1;
    #1 check_all_zero("rst_mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    err_exp = 0;
    wait_idle(100, "rst_idle");
    check("rst_nwr", wr_ev.size(), 3);
    if (wr_ev.size() == 3)
      check("rst_wr_seq", {wr_ev[0].a, wr_ev[1].a, wr_ev[2].a, wr_ev[2].d}, 32'h515354A4);
    check("rst_ntx", tx_ev.size(), 3);
    check("rst_err", err_count, 0);

    // -------- randomized commands against a transaction-level model --------
    clear_ev();
    exp_tx.delete(); exp_wr.delete(); exp_rd.delete();
    drain_pct = 30;
    for (int k = 0; k < 40; k++) begin
      logic [1:0] typ;
      logic [7:0] a, d, rdv;
      int l;
      typ = 2'($urandom_range(3));
      a   = 8'($urandom);
      d   = 8'($urandom);
      push_cmd(typ, a, d);
      case (typ)
        2'd1: begin exp_wr.push_back({a, d}); exp_tx.push_back(8'hA5); end
        2'd2: begin
          exp_rd.push_back(a);
          l   = ($urandom_range(9) == 0) ? -1 : int'($urandom_range(1, 12));
          rdv = 8'($urandom);
          lat_q.push_back(l);
          rdd_q.push_back(rdv);
          if (l > 0 && l <= RD_TIMEOUT - 1) begin
            exp_tx.push_back(8'hAD); exp_tx.push_back(rdv);
          end else begin
            exp_tx.push_back(8'hEF); err_exp = sat(err_exp + 1);
          end
        end
        2'd3: begin exp_tx.push_back(8'hEE); err_exp = sat(err_exp + 1); end
        default: ;
      endcase
    end
    wait_idle(8000, "rand_idle");
    check("rand_ntx", tx_ev.size(), exp_tx.size());
    check("rand_nwr", wr_ev.size(), exp_wr.size());
    check("rand_nrd", rd_ev.size(), exp_rd.size());
    for (int k = 0; k < exp_tx.size() && k < tx_ev.size(); k++)
      check($sformatf("rand_tx%0d", k), tx_ev[k].d, exp_tx[k]);
    for (int k = 0; k < exp_wr.size() && k < wr_ev.size(); k++)
      check($sformatf("rand_wr%0d", k), {wr_ev[k].a, wr_ev[k].d}, exp_wr[k]);
    for (int k = 0; k < exp_rd.size() && k < rd_ev.size(); k++)
      check($sformatf("rand_rd%0d", k), rd_ev[k].a, exp_rd[k]);
    check("rand_err", err_count, err_exp);

    // -------- error counter saturation --------
    clear_ev();
    drain_pct = 100;
    for (int k = 0; k < 260; k++) push_cmd(2'd3, 8'(k), 8'h00);
    wait_idle(4000, "sat_idle");
    err_exp = sat(err_exp + 260);
    check("sat_ntx", tx_ev.size(), 260);
    check("sat_err", err_count, err_exp);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
